// File: rtl/serial_word_serializer.sv
// rtl/serial_word_serializer.sv - MSB-first parallel-to-serial word front end with a one-word holding buffer.
// Words are framed with out_first/out_last so a bit-serial checker can restart its state per word.
module serial_word_serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, SHIFT_HELD} state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LEN_W-1:0] hold_len_q, hold_len_d;

  logic             hold_full;
  logic             accept;
  logic             free;
  logic             ld_en;
  logic [WIDTH-1:0] ld_data;
  logic [LEN_W-1:0] ld_len;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
  endfunction

  function automatic logic pick(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] idx);
    logic [WIDTH-1:0] s;
    s = d >> idx;
    return s[0];
  endfunction

  assign out_valid = (state_q != IDLE);
  assign hold_full = (state_q == SHIFT_HELD);
  assign in_ready  = !hold_full && !reset;
  assign busy      = out_valid || hold_full;
  assign out_bit   = bit_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign accept    = in_valid && in_ready;
  // Shifter can take a new word when empty or when its final bit leaves this cycle.
  assign free      = !out_valid || (out_ready && last_q);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    first_d     = first_q;
    last_d      = last_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    ld_en       = 1'b0;
    ld_data     = hold_data_q;
    ld_len      = hold_len_q;

    if (free) begin
      if (hold_full) begin
        ld_en = 1'b1;
      end else if (accept) begin
        ld_en   = 1'b1;
        ld_data = in_data;
        ld_len  = eff_len(in_len);
      end else begin
        state_d = IDLE;
        bit_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      if (out_ready) begin
        bit_d   = pick(data_q, cnt_q - ONE);
        cnt_d   = cnt_q - ONE;
        first_d = 1'b0;
        last_d  = (cnt_q == ONE);
      end
      if (accept) begin
        hold_data_d = in_data;
        hold_len_d  = eff_len(in_len);
        state_d     = SHIFT_HELD;
      end
    end

    if (ld_en) begin
      state_d = SHIFT;
      data_d  = ld_data;
      bit_d   = pick(ld_data, ld_len - ONE);
      first_d = 1'b1;
      last_d  = (ld_len == ONE);
      cnt_d   = ld_len - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      bit_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      first_q     <= first_d;
      last_q      <= last_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
    end
  end

endmodule

// File: tb/tb_serial_word_serializer.sv
// tb/tb_serial_word_serializer.sv - directed and random checks of serial_word_serializer against a bit-queue model.
module tb_serial_word_serializer;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_bit;
  logic             out_first;
  logic             out_last;
  logic             busy;

  serial_word_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Expected stream entries: {bit, first, last}; outstanding = words accepted but not fully sent.
  logic [2:0] exp_q[$];
  int         outstanding = 0;
  logic       accepted;
  logic       stall_pending = 1'b0;
  logic [3:0] stall_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] len);
    int l;
    l = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
    for (int i = 0; i < l; i++)
      exp_q.push_back({d[l-1-i], i == 0, i == l - 1});
    outstanding++;
  endtask

  task automatic cycle();
    logic       xfer;
    logic [2:0] e;
    accepted = in_valid && in_ready;
    xfer     = out_valid && out_ready;
    check("out_valid", out_valid, outstanding > 0);
    check("in_ready", in_ready, outstanding < 2);
    check("busy", busy, outstanding > 0);
    if (!out_valid) check("idle_flags", {out_first, out_last}, 2'b00);
    if (stall_pending) check("stall_hold", {out_valid, out_bit, out_first, out_last}, stall_snap);
    stall_pending = out_valid && !out_ready;
    stall_snap    = {1'b1, out_bit, out_first, out_last};
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bit_first_last", {out_bit, out_first, out_last}, e);
        if (e[0]) outstanding--;
      end
    end
    if (accepted) push_word(in_data, in_len);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] len);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len;
    guard    = 0;
    accepted = 1'b0;
    while (!accepted && guard < 50) begin
      cycle();
      guard++;
    end
    if (!accepted) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (outstanding > 0 && guard < 60) begin
      cycle();
      guard++;
    end
    cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("in_ready_in_reset", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_outs", {out_valid, out_bit, out_first, out_last, busy}, 5'b0);
    exp_q.delete();
    outstanding   = 0;
    stall_pending = 1'b0;
    reset         = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // A5 len 8 streamed with out_ready high
    out_ready = 1'b1;
    send(8'hA5, 4'd8);
    drain();

    // back-to-back: second word waits in hold
    send(8'h03, 4'd2);
    send(8'hFF, 4'd3);
    drain();

    // stall after the second bit
    send(8'hC3, 4'd8);
    cycle();
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    drain();

    // length edges
    send(8'h01, 4'd1);
    drain();
    send(8'h80, 4'd0);
    drain();
    send(8'h5A, 4'd12);
    drain();

    // reset mid-word with hold full
    send(8'hA5, 4'd8);
    send(8'h3C, 4'd8);
    cycle();
    check("hold_full_in_ready", in_ready, 0);
    do_reset();
    out_ready = 1'b1;
    send(8'h06, 4'd3);
    drain();

    // bypass on the last-bit transfer
    send(8'h03, 4'd2);
    cycle();
    send(8'h05, 4'd3);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = WIDTH'($urandom);
      in_len    = LEN_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
